// File: rtl/regfile_mp.sv
// Multi-port integer register file with a per-register busy scoreboard; x0 reads as zero and is never busy.
// Optional same-cycle write-to-read forwarding is compiled in with `define REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2,
    parameter int NWR    = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NRD-1:0]        rd_en,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*ADDR_W-1:0] wr_addr,
    input  logic [NWR*DATA_W-1:0] wr_data,
    input  logic                  iss_en,
    input  logic [ADDR_W-1:0]     iss_addr,
    output logic                  any_busy
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] wr_val [NREG];
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;
    logic [NREG-1:0]   wr_hit;

    // Ports are scanned in ascending order so the highest-index writer overrides the others.
    always_comb begin
        wr_hit = '0;
        for (int r = 0; r < NREG; r++) begin
            wr_val[r] = regs_q[r];
        end
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && wr_addr[w*ADDR_W +: ADDR_W] != '0) begin
                wr_hit[wr_addr[w*ADDR_W +: ADDR_W]] = 1'b1;
                wr_val[wr_addr[w*ADDR_W +: ADDR_W]] = wr_data[w*DATA_W +: DATA_W];
            end
        end
        // Issue is applied after writeback clear: a new producer outranks the retiring one.
        busy_d = busy_q & ~wr_hit;
        if (iss_en && iss_addr != '0) begin
            busy_d[iss_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            busy_q <= '0;
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            for (int r = 0; r < NREG; r++) begin
                if (wr_hit[r]) begin
                    regs_q[r] <= wr_val[r];
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            if (!RST && rd_en[k] && rd_addr[k*ADDR_W +: ADDR_W] != '0) begin
                rd_data[k*DATA_W +: DATA_W] = regs_q[rd_addr[k*ADDR_W +: ADDR_W]];
                rd_busy[k]                  = busy_q[rd_addr[k*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
                for (int w = 0; w < NWR; w++) begin
                    if (wr_en[w] && wr_addr[w*ADDR_W +: ADDR_W] == rd_addr[k*ADDR_W +: ADDR_W]) begin
                        rd_data[k*DATA_W +: DATA_W] = wr_data[w*DATA_W +: DATA_W];
                        rd_busy[k]                  = 1'b0;
                    end
                end
`endif
            end
        end
    end

    assign any_busy = !RST && (|busy_q);

endmodule

// File: tb/tb_regfile_mp.sv
// Directed plus randomized bench for regfile_mp (2 read, 2 write ports) against an array-based model.
// Expectations follow REGFILE_BYPASS_EN the same way the design does.
module tb_regfile_mp;

    logic        CLK = 1'b0;
    logic        RST;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        any_busy;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_q[$];
    logic [31:0] m_reg [32];
    bit          m_busy [32];

    regfile_mp #(.DATA_W(32), .NREG(32), .ADDR_W(5), .NRD(2), .NWR(2)) dut (
        .CLK(CLK), .RST(RST),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .any_busy(any_busy)
    );

    // clock and reset
    always #5 CLK = ~CLK;

    task automatic model_clear();
        for (int r = 0; r < 32; r++) begin
            m_reg[r]  = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    // reference model: expected read data / busy for port k given the current inputs
    function automatic logic [31:0] exp_rd(int k);
        logic [4:0]  a = rd_addr[k*5 +: 5];
        logic [31:0] d;
        if (RST || !rd_en[k] || a == 5'd0) return 32'd0;
        d = m_reg[a];
`ifdef REGFILE_BYPASS_EN
        for (int w = 0; w < 2; w++)
            if (wr_en[w] && wr_addr[w*5 +: 5] == a) d = wr_data[w*32 +: 32];
`endif
        return d;
    endfunction

    function automatic logic [31:0] exp_bz(int k);
        logic [4:0] a = rd_addr[k*5 +: 5];
        bit         b;
        if (RST || !rd_en[k] || a == 5'd0) return 32'd0;
        b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
        for (int w = 0; w < 2; w++)
            if (wr_en[w] && wr_addr[w*5 +: 5] == a) b = 1'b0;
`endif
        return 32'(b);
    endfunction

    function automatic logic [31:0] exp_any();
        bit b = 1'b0;
        if (RST) return 32'd0;
        for (int r = 0; r < 32; r++) b = b | m_busy[r];
        return 32'(b);
    endfunction

    // scoreboard
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        logic [31:0] e;
        exp_q.push_back(expv);
        e = exp_q.pop_front();
        tests++;
        assert (obs === e) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    task automatic check_outputs(string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_data%0d", tag, k), rd_data[k*32 +: 32], exp_rd(k));
            chk($sformatf("%s_busy%0d", tag, k), 32'(rd_busy[k]), exp_bz(k));
        end
        chk($sformatf("%s_any", tag), 32'(any_busy), exp_any());
    endtask

    // model state update on the rising edge, then step off the edge
    task automatic tick();
        @(posedge CLK);
        if (!RST) begin
            for (int w = 0; w < 2; w++)
                if (wr_en[w] && wr_addr[w*5 +: 5] != 5'd0) begin
                    m_reg[wr_addr[w*5 +: 5]]  = wr_data[w*32 +: 32];
                    m_busy[wr_addr[w*5 +: 5]] = 1'b0;
                end
            if (iss_en && iss_addr != 5'd0) m_busy[iss_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic cyc(string tag);
        @(negedge CLK);
        check_outputs(tag);
        tick();
    endtask

    // driver tasks
    task automatic idle();
        rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0;
    endtask

    task automatic wr(int p, int a, logic [31:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p*5 +: 5] = 5'(a);
        wr_data[p*32 +: 32] = d;
    endtask

    task automatic rd(int p, int a);
        rd_en[p] = 1'b1;
        rd_addr[p*5 +: 5] = 5'(a);
    endtask

    task automatic iss(int a);
        iss_en = 1'b1;
        iss_addr = 5'(a);
    endtask

    function automatic int rnd_addr();
        return ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 5));
    endfunction

    initial begin
        model_clear();
        idle();
        RST = 1'b1;
        rd(0, 5); rd(1, 9); wr(0, 5, 32'h1111_2222); iss(9);
        #3;
        check_outputs("rst_init");
        chk("rst_init_lit", rd_data[31:0], 32'd0);
        repeat (2) @(posedge CLK);
        idle();
        @(negedge CLK);
        #1 RST = 1'b0;
        tick();

        // load r5, mark r9 busy, then reset mid-cycle
        idle(); wr(0, 5, 32'hDEAD_BEEF); iss(9); cyc("w5");
        idle(); rd(0, 5); rd(1, 9); cyc("r5");
        chk("r5_lit", rd_data[31:0], 32'hDEAD_BEEF);
        idle(); rd(0, 5); rd(1, 9); wr(1, 6, 32'h0BAD_F00D);
        #2 RST = 1'b1;
        model_clear();
        #1;
        check_outputs("rst_mid");
        chk("rst_mid_r5", rd_data[31:0], 32'd0);
        chk("rst_mid_any", 32'(any_busy), 32'd0);
        @(negedge CLK);
        #1 RST = 1'b0;
        idle();
        tick();
        idle(); rd(0, 5); cyc("post_rst");

        // x0 protection
        idle(); wr(0, 0, 32'h1234_5678); cyc("x0w");
        idle(); rd(0, 0); iss(0); cyc("x0r");
        idle(); #1 chk("x0_any", 32'(any_busy), 32'd0);

        // write conflict on r7: port 1 wins
        idle(); wr(0, 7, 32'h11); wr(1, 7, 32'h22); cyc("conf");
        idle(); rd(0, 7); #1 chk("conf_lit", rd_data[31:0], 32'h22);
        cyc("conf_r");

        // same-cycle write and read of r3 (r3 busy beforehand)
        idle(); iss(3); cyc("byp_iss");
        idle(); wr(0, 3, 32'hA5A5_A5A5); rd(1, 3); #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_data", rd_data[63:32], 32'hA5A5_A5A5);
        chk("byp_busy", 32'(rd_busy[1]), 32'd0);
`else
        chk("byp_data", rd_data[63:32], 32'd0);
        chk("byp_busy", 32'(rd_busy[1]), 32'd1);
`endif
        cyc("byp");
        idle(); rd(1, 3); #1 chk("byp_next", rd_data[63:32], 32'hA5A5_A5A5);
        cyc("byp_n");

        // scoreboard set/clear on r9
        idle(); iss(9); cyc("sb_iss");
        idle(); rd(0, 9); #1;
        chk("sb_busy1", 32'(rd_busy[0]), 32'd1);
        chk("sb_any1", 32'(any_busy), 32'd1);
        cyc("sb_set");
        idle(); wr(0, 9, 32'h99); cyc("sb_wb");
        idle(); rd(0, 9); #1;
        chk("sb_busy0", 32'(rd_busy[0]), 32'd0);
        chk("sb_any0", 32'(any_busy), 32'd0);
        cyc("sb_clr");

        // issue and writeback to busy r4 in the same cycle: stays busy
        idle(); iss(4); cyc("svc_iss");
        idle(); iss(4); wr(0, 4, 32'h5); cyc("svc");
        idle(); rd(0, 4); #1;
        chk("svc_data", rd_data[31:0], 32'h5);
        chk("svc_busy", 32'(rd_busy[0]), 32'd1);
        chk("svc_any", 32'(any_busy), 32'd1);
        cyc("svc_r");

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            idle();
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 3) != 0) rd(p, rnd_addr());
                if ($urandom_range(0, 2) == 0) wr(p, rnd_addr(), $urandom);
            end
            if ($urandom_range(0, 2) == 0) iss(rnd_addr());
            cyc("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
